div_unit_ex: RTL and testbench

Iterative 32-bit integer divider for the EX stage, the inverse companion of the multiply-accumulate unit. Computes quotient and remainder for MIPS DIV (signed) and DIVU (unsigned) by restoring shift-subtract, one quotient bit per clock. Results go to the LO (quotient) and HI (remainder) registers. The stall logic holds the pipeline while `busy` is high.

---
 rtl/div_unit_ex.sv | 152 +++++++++++++++
 tb/tb_div_unit_ex.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit_ex.sv
// rtl/div_unit_ex.sv - iterative restoring shift-subtract divider for MIPS DIV/DIVU
// One quotient bit per clock; results land in LO (quotient) and HI (remainder).
module div_unit_ex #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_unit_activation_signal,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] div_input1,
  input  logic [WIDTH-1:0] div_input2,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    cnt_q;
  logic             zero_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] quo_out_q;
  logic [WIDTH-1:0] rem_out_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             start_zero;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    a_neg      = signed_op & div_input1[WIDTH-1];
    b_neg      = signed_op & div_input2[WIDTH-1];
    a_mag      = a_neg ? (-div_input1) : div_input1;
    b_mag      = b_neg ? (-div_input2) : div_input2;
    start_zero = (div_input2 == '0);
  end

  // The true difference always fits in WIDTH bits, so the subtract is done
  // modulo 2^WIDTH while the compare uses the full WIDTH+1 bit partial remainder.
  always_comb begin
    rem_shift = {rem_q, dvd_q[WIDTH-1]};
    rem_sub   = rem_shift[WIDTH-1:0] - dvs_q;
    rem_ge    = (rem_shift >= {1'b0, dvs_q});
    rem_d     = rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
    dvd_d     = {dvd_q[WIDTH-2:0], rem_ge};
  end

  always_comb begin
    quo_fix = neg_quo_q ? (-dvd_q) : dvd_q;
    rem_fix = neg_rem_q ? (-rem_q) : rem_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      zero_q    <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          dbz_q  <= 1'b0;
          // A zero divisor keeps the raw dividend in dvd_q for the HI result.
          if (div_unit_activation_signal) begin
            busy_q    <= 1'b1;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dvs_q     <= b_mag;
            rem_q     <= '0;
            cnt_q     <= '0;
            zero_q    <= start_zero;
            dvd_q     <= start_zero ? div_input1 : a_mag;
            state_q   <= start_zero ? FIX : CALC;
          end
        end
        CALC: begin
          done_q <= 1'b0;
          dbz_q  <= 1'b0;
          rem_q  <= rem_d;
          dvd_q  <= dvd_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          dbz_q     <= zero_q;
          quo_out_q <= zero_q ? '1 : quo_fix;
          rem_out_q <= zero_q ? dvd_q : rem_fix;
          state_q   <= IDLE;
          // Completion is also the idle point, so a waiting start is taken here.
          if (div_unit_activation_signal) begin
            busy_q    <= 1'b1;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dvs_q     <= b_mag;
            rem_q     <= '0;
            cnt_q     <= '0;
            zero_q    <= start_zero;
            dvd_q     <= start_zero ? div_input1 : a_mag;
            state_q   <= start_zero ? FIX : CALC;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          dbz_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign div_by_zero   = dbz_q;
  assign quotient_out  = quo_out_q;
  assign remainder_out = rem_out_q;

endmodule

// File: tb/tb_div_unit_ex.sv
// tb/tb_div_unit_ex.sv - directed vector bench for div_unit_ex
module tb_div_unit_ex;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        dbz;
  logic [31:0] quo;
  logic [31:0] rem;

  int total;
  int bad;

  div_unit_ex #(.WIDTH(32)) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .div_unit_activation_signal (start),
    .signed_op                  (signed_op),
    .div_input1                 (a),
    .div_input2                 (b),
    .busy                       (busy),
    .done                       (done),
    .div_by_zero                (dbz),
    .quotient_out               (quo),
    .remainder_out              (rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   n;
    logic got;
    logic busy_ok;
    @(negedge clk);
    signed_op = v.s;
    a         = v.a;
    b         = v.b;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    busy_ok = busy;
    n       = 0;
    got     = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (done) got = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    chk($sformatf("v%0d_latency", idx), n, v.lat);
    chk($sformatf("v%0d_busy_during", idx), {31'd0, busy_ok}, 32'd1);
    chk($sformatf("v%0d_busy_at_done", idx), {31'd0, busy}, 32'd0);
    chk($sformatf("v%0d_quotient", idx), quo, v.q);
    chk($sformatf("v%0d_remainder", idx), rem, v.r);
    chk($sformatf("v%0d_dbz", idx), {31'd0, dbz}, {31'd0, v.z});
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_done_drop", idx), {30'd0, done, dbz}, 32'd0);
  endtask

  initial begin
    int          ndone;
    int          first;
    logic [31:0] q1;
    logic [31:0] r1;
    vec_t        v;

    total = 0;
    bad   = 0;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 33};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 33};
    vecs[3]  = '{1'b0, 32'hDEADBEEF,   32'd0,          32'hFFFFFFFF,   32'hDEADBEEF,   1'b1, 1};
    vecs[4]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
    vecs[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 33};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 33};
    vecs[7]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, 33};
    vecs[8]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, 33};
    vecs[9]  = '{1'b1, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 1};
    vecs[10] = '{1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1, 1};
    vecs[11] = '{1'b0, 32'd3,          32'd5,          32'd0,          32'd3,          1'b0, 33};

    rst_n     = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", {29'd0, busy, done, dbz}, 32'd0);
    chk("reset_quotient", quo, 32'd0);
    chk("reset_remainder", rem, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Start pulse at E10 while busy, with operands scrambled after E0.
    @(negedge clk);
    signed_op = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk);
    ndone = 0; first = 0; q1 = '0; r1 = '0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      start = (c == 10);
      a = 32'h0000FFFF; b = 32'd0; signed_op = 1'b1;
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (ndone == 1) begin first = c; q1 = quo; r1 = rem; end
      end
    end
    chk("ignored_start_done_count", ndone, 32'd1);
    chk("ignored_start_done_cycle", first, 32'd33);
    chk("ignored_start_quotient", q1, 32'd14);
    chk("ignored_start_remainder", r1, 32'd2);

    // Start held high across completion: back-to-back acceptance at E33.
    @(negedge clk);
    signed_op = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk);
    ndone = 0; first = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      a = 32'd9; b = 32'd3;
      if (c == 34) start = 1'b0;
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          chk("held_first_cycle", c, 32'd33);
          chk("held_first_quotient", quo, 32'd14);
          chk("held_first_remainder", rem, 32'd2);
        end else if (ndone == 2) begin
          chk("held_second_cycle", c, 32'd66);
          chk("held_second_quotient", quo, 32'd3);
          chk("held_second_remainder", rem, 32'd0);
        end
      end
    end
    chk("held_done_count", ndone, 32'd2);

    // Reset at E15 mid-divide abandons the operation.
    @(negedge clk);
    signed_op = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk);
    ndone = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = 1'b0;
      rst_n = (c != 15);
      @(posedge clk);
      #1;
      if (c == 15) begin
        chk("midreset_flags", {29'd0, busy, done, dbz}, 32'd0);
        chk("midreset_quotient", quo, 32'd0);
        chk("midreset_remainder", rem, 32'd0);
      end
      if (done) ndone++;
    end
    chk("midreset_no_done", ndone, 32'd0);

    v = '{1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33};
    run_vec(12, v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
